prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL provide parameter AW, default 8, program address and data width, legal range 8..16.
REQ-002 SHALL provide parameter DEPTH, default 4, return-stack entries, legal range 1..16.
REQ-003 SHALL provide parameter IRQ_VEC, default {AW{1'b1}}-1, interrupt target address.
REQ-004 SHALL provide port clk, input, 1, clock; sole clock, all state updates on rising edge.
REQ-005 SHALL provide port reset, input, 1, reset; synchronous, active-high.
REQ-006 SHALL provide port irq, input, 1, level interrupt request.
REQ-007 SHALL provide port mem_data, input, AW, program memory word for the address driven on pc one cycle earlier (synchronous read).
REQ-008 SHALL provide port eq, input, 1, datapath compare result for BEQ/BNE, sampled in OPERAND.
REQ-009 SHALL provide port pc, output, AW, program memory read address (registered).
REQ-010 SHALL provide port op_reg, output, 8, opcode of the instruction in progress (registered).
REQ-011 SHALL provide port op_valid, output, 1, pulse: one-cycle opcode (0x0-0x7) executes this cycle; the opcode is mem_data[7:0].
REQ-012 SHALL provide port opnd_valid, output, 1, pulse: LD/ST/LDUMEM (0x8/0xE/0xF) operand on mem_data this cycle.
REQ-013 SHALL provide port sp, output, $clog2(DEPTH+1), stack occupancy.
REQ-014 SHALL provide ports ovf, unf, output, 1 each, sticky stack overflow/underflow flags.
REQ-015 SHALL provide port in_isr, output, 1, interrupt service active.

Function
REQ-016 SHALL have states FETCH, OPERAND, FLUSH; in FETCH/OPERAND mem_data holds the word at address pc-1.
REQ-017 SHALL increment pc by 1 modulo 2^AW every cycle except when a jump loads it.
REQ-018 FETCH: opcode 0x0-0x7 -> op_valid=1, stay FETCH; 8'h9F NOP -> stay FETCH; upper nibble 0xB -> RTS; any other opcode -> latch op_reg, go OPERAND.
REQ-019 OPERAND: JMP (0x9) loads pc <= mem_data; CALL (0xA) pushes pc, then loads pc <= mem_data; BEQ (0xC) jumps if eq=1; BNE (0xD) jumps if eq=0; jumps go FLUSH, else go FETCH.
REQ-020 OPERAND with opcode 0x8/0xE/0xF SHALL assert opnd_valid for one cycle and go FETCH; opcodes 0x9-0xD SHALL NOT assert it.
REQ-021 RTS SHALL pop the top entry into pc and go FLUSH; RTS with sp=0 sets unf, leaves pc incrementing, stays FETCH.
REQ-022 CALL with sp=DEPTH SHALL set ovf, not push, not jump, and go FETCH.
REQ-023 FLUSH SHALL last exactly one cycle, discard mem_data, assert no pulses, and go FETCH.
REQ-024 Jump latency: the target instruction is on mem_data two cycles after the jump decision edge.
REQ-025 ovf/unf SHALL stay set until reset.
REQ-026 SHALL cause pc to wrap from 2^AW-1 to 0 with no flag raised.

Reset
REQ-027 On reset: pc=0, state=FLUSH, op_reg=0, sp=0, stack contents don't-care, ovf=unf=in_isr=0, op_valid=opnd_valid=0.
REQ-028 Reset SHALL take priority over irq and any in-flight instruction; a reset in OPERAND SHALL discard the operand.

Configuration
REQ-029 With SEQ_IRQ_EN defined: irq sampled only in FETCH while in_isr=0 and sp<DEPTH; when sampled, push pc-1, load pc <= IRQ_VEC, set in_isr, go FLUSH, suppress op_valid.
REQ-030 With SEQ_IRQ_EN defined: 8'hBF is RTI (RTS plus in_isr clear); irq with sp=DEPTH SHALL stay pending and not set ovf.
REQ-031 Without SEQ_IRQ_EN: irq is ignored, in_isr is constant 0, and 8'hBF is a plain RTS.

Verification
REQ-032 Reset, mem[0]=0x12, mem[1]=0x9F -> FLUSH one cycle, then op_valid=1 with mem_data=0x12, then a NOP cycle, pc=3.
REQ-033 mem[4]=0xA0, mem[5]=0x40, mem[0x40]=0xB0 -> sp 0->1, pc=0x40, FLUSH, RTS pops 6, mem[6] executes next, sp=0.
REQ-034 DEPTH=2, three nested CALLs -> third sets ovf=1, sp stays 2, execution continues at the word after its operand.
REQ-035 RTS at sp=0 -> unf=1, no jump, next sequential instruction executes.
REQ-036 SEQ_IRQ_EN, irq=1 while FETCH holds 0x12 at address 7 -> no op_valid, pc=IRQ_VEC (0xFE), in_isr=1; RTI -> pc=7, 0x12 executes, in_isr=0.
REQ-037 BEQ 0x20 with eq=0 -> no jump, no FLUSH; with eq=1 -> pc=0x20, one FLUSH cycle.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: program sequencer with FETCH / OPERAND / FLUSH control,
// a return-address stack with sticky overflow/underflow flags, and an
// optional interrupt entry path.
// Optional feature macro: SEQ_IRQ_EN enables irq servicing and makes 8'hBF
// an RTI (return plus in_isr clear). Without it irq is ignored.
// seq_state exposes the control state: 0=FETCH, 1=OPERAND, 2=FLUSH.
// Valid semantics: op_valid and opnd_valid are single-cycle qualifiers on the
// current mem_data word. There is no back-pressure. The sequencer always
// advances, so each pulse means "consume this word now".
module prog_sequencer #(
    parameter int              AW      = 8,
    parameter int              DEPTH   = 4,
    parameter logic [AW-1:0]   IRQ_VEC = {{(AW-1){1'b1}}, 1'b0}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         irq,
    input  logic [AW-1:0]                mem_data,
    input  logic                         eq,
    output logic [AW-1:0]                pc,
    output logic [7:0]                   op_reg,
    output logic                         op_valid,
    output logic                         opnd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         ovf,
    output logic                         unf,
    output logic                         in_isr,
    output logic [1:0]                   seq_state
);

    localparam int             SPW     = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        OPERAND = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t state, state_next;

    // Sized to the full index range so the pointer never selects out of
    // bounds. Entries at or above DEPTH are never written.
    logic [AW-1:0] stack_mem [0:(2**SPW)-1];
    logic [AW-1:0] stack_top;

    logic          is_single, is_nop, is_rts, is_rti, irq_take;
    logic          stack_empty, stack_full;
    logic [AW-1:0] pc_next, push_val;
    logic          do_push, do_pop, set_ovf, set_unf, latch_op, isr_clr, jump;

    assign is_single   = ~mem_data[7];
    assign is_nop      = (mem_data[7:0] == 8'h9F);
    assign is_rts      = (mem_data[7:4] == 4'hB);
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_FULL);
    assign stack_top   = stack_mem[sp - SPW'(1)];
    assign seq_state   = state;

`ifdef SEQ_IRQ_EN
    // Interrupts are taken only at an instruction boundary, one level deep,
    // and only when the return address can be stacked.
    assign irq_take = (state == FETCH) && irq && !in_isr && !stack_full;
    assign is_rti   = (mem_data[7:0] == 8'hBF);

    // Interrupt-service flag: set on entry, cleared by a successful RTI
    always_ff @(posedge clk) begin
        if (reset)         in_isr <= 1'b0;
        else if (irq_take) in_isr <= 1'b1;
        else if (isr_clr)  in_isr <= 1'b0;
    end
`else
    logic irq_unused;
    assign irq_take   = 1'b0;
    assign is_rti     = 1'b0;
    assign in_isr     = 1'b0;
    assign irq_unused = irq | isr_clr;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FLUSH;
        else       state <= state_next;
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        pc_next    = pc + AW'(1);
        push_val   = pc;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        latch_op   = 1'b0;
        isr_clr    = 1'b0;
        jump       = 1'b0;
        case (state)
            FETCH: begin
                if (irq_take) begin
                    // Return to the word now on mem_data so it is re-executed
                    do_push    = 1'b1;
                    push_val   = pc - AW'(1);
                    pc_next    = IRQ_VEC;
                    state_next = FLUSH;
                end else if (is_rts) begin
                    if (stack_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        do_pop     = 1'b1;
                        pc_next    = stack_top;
                        isr_clr    = is_rti;
                        state_next = FLUSH;
                    end
                end else if (!is_single && !is_nop) begin
                    latch_op   = 1'b1;
                    state_next = OPERAND;
                end
            end
            OPERAND: begin
                state_next = FETCH;
                case (op_reg[7:4])
                    4'h9: jump = 1'b1;
                    4'hA: begin
                        if (stack_full) begin
                            set_ovf = 1'b1;
                        end else begin
                            do_push = 1'b1;
                            jump    = 1'b1;
                        end
                    end
                    4'hC:    jump = eq;
                    4'hD:    jump = ~eq;
                    default: jump = 1'b0;
                endcase
                if (jump) begin
                    pc_next    = mem_data;
                    state_next = FLUSH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Output pulses qualify the word currently on mem_data
    always_comb begin
        op_valid   = 1'b0;
        opnd_valid = 1'b0;
        if (state == FETCH)
            op_valid = is_single && !irq_take;
        if (state == OPERAND)
            opnd_valid = (op_reg[7:4] == 4'h8) || (op_reg[7:4] == 4'hE) ||
                         (op_reg[7:4] == 4'hF);
    end

    // Program counter, opcode latch, stack pointer and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            op_reg <= 8'h00;
            sp     <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            pc <= pc_next;
            if (latch_op) op_reg <= mem_data[7:0];
            if (do_push)     sp <= sp + SPW'(1);
            else if (do_pop) sp <= sp - SPW'(1);
            if (set_ovf) ovf <= 1'b1;
            if (set_unf) unf <= 1'b1;
        end
    end

    // Return-stack storage; contents need no reset
    always_ff @(posedge clk) begin
        if (!reset && do_push) stack_mem[sp] <= push_val;
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Testbench for prog_sequencer: directed scenarios plus randomized programs,
// all checked against an instruction-level reference model of the sequencer.
module tb_prog_sequencer;

    localparam int AW       = 8;
    localparam int DEPTH    = 2;
    localparam int IRQ_VEC  = 8'hFE;
    localparam int PH_FETCH = 0;
    localparam int PH_OPND  = 1;
    localparam int PH_FLUSH = 2;
`ifdef SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq = 1'b0;
    logic eq = 1'b0;
    logic [AW-1:0] mem_data;
    logic [AW-1:0] pc;
    logic [7:0]    op_reg;
    logic          op_valid, opnd_valid, ovf, unf, in_isr;
    logic [1:0]    sp;
    logic [1:0]    seq_state;

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    always @(posedge clk) mem_data <= mem[pc];

    prog_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .irq(irq), .mem_data(mem_data), .eq(eq),
        .pc(pc), .op_reg(op_reg), .op_valid(op_valid), .opnd_valid(opnd_valid),
        .sp(sp), .ovf(ovf), .unf(unf), .in_isr(in_isr), .seq_state(seq_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_pc, m_phase, m_op, m_word;
    int  m_stk[$];
    bit  m_ovf, m_unf, m_isr;
    bit  model_ok = 1'b0;

    function automatic bit m_irq_taken();
        return IRQ_EN && m_phase == PH_FETCH && irq && !m_isr && m_stk.size() < DEPTH;
    endfunction

    task automatic model_check();
        int hi;
        hi = m_op >> 4;
        check("pc", pc, m_pc);
        check("sp", sp, m_stk.size());
        check("ovf", ovf, m_ovf);
        check("unf", unf, m_unf);
        check("in_isr", in_isr, m_isr);
        check("op_reg", op_reg, m_op);
        check("state", seq_state, m_phase);
        check("op_valid", op_valid, m_phase == PH_FETCH && !m_irq_taken() && m_word < 8'h80);
        check("opnd_valid", opnd_valid, m_phase == PH_OPND && (hi == 8 || hi == 14 || hi == 15));
    endtask

    // Advance the model by the clock edge about to happen
    task automatic model_advance();
        int nxt;
        bit jmp;
        if (reset) begin
            m_pc = 0; m_phase = PH_FLUSH; m_op = 0; m_word = 0;
            m_stk.delete();
            m_ovf = 0; m_unf = 0; m_isr = 0;
            model_ok = 1'b1;
            return;
        end
        if (!model_ok) return;
        nxt = (m_pc + 1) % 256;
        jmp = 1'b0;
        if (m_phase == PH_FETCH) begin
            if (m_irq_taken()) begin
                m_stk.push_back((m_pc + 255) % 256);
                nxt = IRQ_VEC; m_isr = 1; m_phase = PH_FLUSH;
            end else if ((m_word >> 4) == 11) begin
                if (m_stk.size() == 0) m_unf = 1;
                else begin
                    nxt = m_stk.pop_back();
                    if (IRQ_EN && m_word == 8'hBF) m_isr = 0;
                    m_phase = PH_FLUSH;
                end
            end else if (m_word >= 8'h80 && m_word != 8'h9F) begin
                m_op = m_word; m_phase = PH_OPND;
            end
        end else if (m_phase == PH_OPND) begin
            case (m_op >> 4)
                9:  jmp = 1;
                10: if (m_stk.size() == DEPTH) m_ovf = 1;
                    else begin m_stk.push_back(m_pc); jmp = 1; end
                12: jmp = eq;
                13: jmp = !eq;
                default: jmp = 0;
            endcase
            if (jmp) begin nxt = m_word; m_phase = PH_FLUSH; end
            else m_phase = PH_FETCH;
        end else begin
            m_phase = PH_FETCH;
        end
        m_word = mem[m_pc];
        m_pc = nxt;
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model follows the edge, then new inputs are applied and
    // the settled outputs are compared mid-cycle.
    task automatic cyc(input bit rst_v, input bit irq_v, input bit eq_v);
        model_advance();
        @(negedge clk);
        reset = rst_v; irq = irq_v; eq = eq_v;
        #1;
        if (!rst_v && model_ok) model_check();
    endtask

    task automatic fill_nop();
        for (int a = 0; a < 256; a++) mem[a] = 8'h9F;
    endtask

    // Leaves the bench in the first post-reset cycle (FLUSH, k=0)
    task automatic start();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
    endtask

    function automatic logic [7:0] rand_byte();
        int n;
        n = $urandom_range(0, 2);
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return 8'($urandom_range(0, 127));
            4: return 8'h9F;
            5: return {4'hB, 4'($urandom_range(0, 15))};
            6: return {4'hA, 4'($urandom_range(0, 15))};
            7: return {($urandom_range(0, 1) == 0) ? 4'hC : 4'hD, 4'($urandom_range(0, 15))};
            8: return {(n == 0) ? 4'h8 : (n == 1) ? 4'hE : 4'hF, 4'($urandom_range(0, 15))};
            default: return {4'h9, 4'($urandom_range(0, 14))};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, single-cycle op, NOP, then run through pc wrap
        fill_nop(); mem[0] = 8'h12; mem[1] = 8'h9F;
        start();
        check("rst_state", seq_state, PH_FLUSH);
        check("rst_pc", pc, 0);
        check("rst_opv", op_valid, 0);
        cyc(0, 0, 0);
        check("seq_opv", op_valid, 1);
        check("seq_data", mem_data, 8'h12);
        cyc(0, 0, 0);
        check("nop_opv", op_valid, 0);
        cyc(0, 0, 0);
        check("nop_pc", pc, 3);
        repeat (254) cyc(0, 0, 0);
        check("wrap_pc", pc, 1);
        check("wrap_flags", {ovf, unf}, 0);

        // CALL / RTS
        fill_nop(); mem[4] = 8'hA0; mem[5] = 8'h40; mem[8'h40] = 8'hB0; mem[6] = 8'h12;
        start();
        repeat (7) cyc(0, 0, 0);
        check("call_pc", pc, 8'h40);
        check("call_sp", sp, 1);
        check("call_flush", seq_state, PH_FLUSH);
        repeat (3) cyc(0, 0, 0);
        check("rts_pc", pc, 7);
        check("rts_opv", op_valid, 1);
        check("rts_sp", sp, 0);

        // Three nested CALLs with a two-entry stack
        fill_nop();
        mem[1] = 8'hA0; mem[2] = 8'h10; mem[8'h10] = 8'hA0; mem[8'h11] = 8'h20;
        mem[8'h20] = 8'hA0; mem[8'h21] = 8'h30; mem[8'h22] = 8'h12;
        start();
        repeat (10) cyc(0, 0, 0);
        check("ovf_flag", ovf, 1);
        check("ovf_sp", sp, 2);
        check("ovf_pc", pc, 8'h23);
        check("ovf_opv", op_valid, 1);

        // RTS on empty stack
        fill_nop(); mem[0] = 8'hB0; mem[1] = 8'h12;
        start();
        repeat (2) cyc(0, 0, 0);
        check("unf_flag", unf, 1);
        check("unf_pc", pc, 2);
        check("unf_opv", op_valid, 1);

        // BEQ not taken, then taken
        fill_nop(); mem[0] = 8'hC0; mem[1] = 8'h20; mem[2] = 8'h12; mem[8'h20] = 8'h13;
        start();
        repeat (3) cyc(0, 0, 0);
        check("beq0_state", seq_state, PH_FETCH);
        check("beq0_data", mem_data, 8'h12);
        check("beq0_pc", pc, 3);
        start();
        repeat (3) cyc(0, 0, 1);
        check("beq1_flush", seq_state, PH_FLUSH);
        check("beq1_pc", pc, 8'h20);
        cyc(0, 0, 1);
        check("beq1_data", mem_data, 8'h13);
        check("beq1_opv", op_valid, 1);

        // Reset landing in OPERAND discards the operand
        fill_nop(); mem[0] = 8'h90; mem[1] = 8'h40;
        start();
        cyc(0, 0, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        check("rstop_pc", pc, 0);
        check("rstop_state", seq_state, PH_FLUSH);
        check("rstop_opreg", op_reg, 0);
        check("rstop_isr", in_isr, 0);

`ifdef SEQ_IRQ_EN
        fill_nop(); mem[7] = 8'h12; mem[8'hFE] = 8'hBF;
        start();
        repeat (7) cyc(0, 0, 0);
        cyc(0, 1, 0);
        check("irq_data", mem_data, 8'h12);
        check("irq_opv", op_valid, 0);
        cyc(0, 0, 0);
        check("irq_pc", pc, 8'hFE);
        check("irq_isr", in_isr, 1);
        repeat (3) cyc(0, 0, 0);
        check("rti_pc", pc, 8);
        check("rti_opv", op_valid, 1);
        check("rti_isr", in_isr, 0);
`else
        fill_nop(); mem[3] = 8'h12;
        start();
        repeat (4) cyc(0, 1, 0);
        check("noirq_opv", op_valid, 1);
        check("noirq_pc", pc, 4);
        check("noirq_isr", in_isr, 0);
`endif

        // Randomized programs, inputs and occasional resets
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = rand_byte();
            start();
            for (int c = 0; c < 800; c++)
                cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
